// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/freeze controller for the RV32I 5-stage core, with a consecutive-stall watchdog.
// Optional perf counters (hazard/mem-stall/flush) are enabled by defining STALL_PERF_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 64,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        if_id_write_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_write_en,
    output logic        mem_wb_write_en,
    output logic        stall_active,
    output logic        stall_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] hazard_stall_cnt,
    output logic [31:0] mem_stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] STALL_MAX  = CNT_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MAX_STALL - 1);

    state_t           state;
    logic [2:0]       fl_cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic freeze, redirect, squash, bubble;

    // Priority: freeze > redirect > post-redirect squash > hazard bubble > run.
    assign freeze   = mem_busy;
    assign redirect = !mem_busy && branch_taken;
    assign squash   = !mem_busy && (branch_taken || state == FLUSH);
    assign bubble   = !mem_busy && !squash && hazard_stall;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_write_en = 1'b1;
        stall_active    = 1'b0;
        if (!rst_n) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            ex_mem_write_en = 1'b0;
            mem_wb_write_en = 1'b0;
        end else if (freeze) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_write_en = 1'b0;
            stall_active    = 1'b1;
        end else if (squash) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (bubble) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
            stall_active   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            fl_cnt <= 3'd0;
        end else if (!mem_busy) begin
            case (state)
                RUN: begin
                    if (branch_taken && FLUSH_CYCLES > 0) begin
                        state  <= FLUSH;
                        fl_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        fl_cnt <= FLUSH_LOAD;
                    end else if (fl_cnt == 3'd1) begin
                        state  <= RUN;
                        fl_cnt <= 3'd0;
                    end else begin
                        fl_cnt <= fl_cnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Watchdog: counts consecutive stall/freeze cycles; timeout is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (stall_active) begin
            if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
            if (stall_cnt == STALL_LAST) stall_timeout <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_stall_cnt <= '0;
            mem_stall_cnt    <= '0;
            flush_cnt        <= '0;
        end else begin
            if (bubble && hazard_stall_cnt != '1) hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
            if (freeze && mem_stall_cnt != '1)    mem_stall_cnt    <= mem_stall_cnt + 32'd1;
            if (redirect && flush_cnt != '1)      flush_cnt        <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (FLUSH_CYCLES=1, MAX_STALL=4).
module tb_pipeline_stall_ctrl;

    // Output vector order: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, stall_active}
    localparam logic [6:0] V_RESET  = 7'b0011000;
    localparam logic [6:0] V_NORM   = 7'b1100110;
    localparam logic [6:0] V_HAZ    = 7'b0001111;
    localparam logic [6:0] V_REDIR  = 7'b1111110;
    localparam logic [6:0] V_FREEZE = 7'b0000001;

    logic clk = 1'b0;
    logic rst_n;
    logic hazard_stall, branch_taken, mem_busy;
    logic pc_write_en, if_id_write_en, if_id_flush, id_ex_flush;
    logic ex_mem_write_en, mem_wb_write_en, stall_active, stall_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] hazard_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_stall    (hazard_stall),
        .branch_taken    (branch_taken),
        .mem_busy        (mem_busy),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write_en (ex_mem_write_en),
        .mem_wb_write_en (mem_wb_write_en),
        .stall_active    (stall_active),
        .stall_timeout   (stall_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .hazard_stall_cnt(hazard_stall_cnt),
        .mem_stall_cnt   (mem_stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    function automatic logic [6:0] outs();
        return {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
                ex_mem_write_en, mem_wb_write_en, stall_active};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, check combinational outputs mid-cycle.
    task automatic cyc(input logic h, input logic b, input logic m,
                       input logic [6:0] exp, input string tag);
        @(posedge clk);
        #1;
        hazard_stall = h;
        branch_taken = b;
        mem_busy     = m;
        @(negedge clk);
        check(tag, {25'd0, outs()}, {25'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0; hazard_stall = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        #3;
        check("reset_outs", {25'd0, outs()}, {25'd0, V_RESET});
        check("reset_timeout", {31'd0, stall_timeout}, 32'd0);
        // Inputs asserted during reset must not leak through.
        branch_taken = 1'b1; mem_busy = 1'b1;
        #1;
        check("reset_overrides_inputs", {25'd0, outs()}, {25'd0, V_RESET});
        branch_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("release_outs", {25'd0, outs()}, {25'd0, V_NORM});
        check("release_timeout", {31'd0, stall_timeout}, 32'd0);

        // Hazard stall for two cycles, then normal.
        cyc(1, 0, 0, V_HAZ,  "haz_c1");
        cyc(1, 0, 0, V_HAZ,  "haz_c2");
        cyc(0, 0, 0, V_NORM, "haz_resume");

        // Branch redirect: two squash cycles, hazard ignored in the second.
        cyc(0, 1, 0, V_REDIR, "br_c1");
        cyc(1, 0, 0, V_REDIR, "br_c2_haz_ignored");
        cyc(0, 0, 0, V_NORM,  "br_done");

        // Freeze for three cycles with a branch in cycle 2: ignored, state stays RUN.
        cyc(0, 0, 1, V_FREEZE, "frz_c1");
        cyc(0, 1, 1, V_FREEZE, "frz_c2_branch");
        cyc(0, 0, 1, V_FREEZE, "frz_c3");
        cyc(0, 0, 0, V_NORM,   "frz_still_run");

        // Freeze inside FLUSH holds the squash counter.
        cyc(0, 1, 0, V_REDIR,  "fl_hold_br");
        cyc(0, 0, 1, V_FREEZE, "fl_hold_freeze");
        cyc(0, 0, 0, V_REDIR,  "fl_hold_still_flush");
        cyc(0, 0, 0, V_NORM,   "fl_hold_done");

        // Branch while in FLUSH reloads the counter.
        cyc(0, 1, 0, V_REDIR, "reload_br1");
        cyc(0, 1, 0, V_REDIR, "reload_br2");
        cyc(0, 0, 0, V_REDIR, "reload_flush");
        cyc(0, 0, 0, V_NORM,  "reload_done");

        // Watchdog: four consecutive stall cycles trip the sticky timeout.
        cyc(1, 0, 0, V_HAZ, "wd_c1");
        cyc(1, 0, 0, V_HAZ, "wd_c2");
        cyc(1, 0, 0, V_HAZ, "wd_c3");
        cyc(1, 0, 0, V_HAZ, "wd_c4");
        check("wd_not_yet", {31'd0, stall_timeout}, 32'd0);
        cyc(0, 0, 0, V_NORM, "wd_ctrl_unaffected");
        check("wd_tripped", {31'd0, stall_timeout}, 32'd1);
        cyc(0, 0, 0, V_NORM, "wd_norm2");
        check("wd_sticky", {31'd0, stall_timeout}, 32'd1);

        // Reset mid-FLUSH abandons it immediately; first cycle after release is RUN.
        cyc(0, 1, 0, V_REDIR, "rst_mid_br");
        @(posedge clk);
        #1 branch_taken = 1'b0; rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {25'd0, outs()}, {25'd0, V_RESET});
        check("rst_mid_timeout", {31'd0, stall_timeout}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_release_run", {25'd0, outs()}, {25'd0, V_NORM});

`ifdef STALL_PERF_CNT_EN
        cyc(1, 0, 0, V_HAZ,    "perf_h1");
        cyc(1, 0, 0, V_HAZ,    "perf_h2");
        cyc(1, 0, 0, V_HAZ,    "perf_h3");
        cyc(0, 0, 1, V_FREEZE, "perf_m1");
        cyc(0, 0, 1, V_FREEZE, "perf_m2");
        cyc(0, 1, 0, V_REDIR,  "perf_b1");
        cyc(0, 0, 0, V_REDIR,  "perf_flush");
        cyc(0, 0, 0, V_NORM,   "perf_idle");
        check("perf_hazard_cnt", hazard_stall_cnt, 32'd3);
        check("perf_mem_cnt",    mem_stall_cnt,    32'd2);
        check("perf_flush_cnt",  flush_cnt,        32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("perf_rst_hazard", hazard_stall_cnt, 32'd0);
        check("perf_rst_mem",    mem_stall_cnt,    32'd0);
        check("perf_rst_flush",  flush_cnt,        32'd0);
        #5 rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
